// File: rtl/uart_pkg.sv
// uart_pkg: constants and types shared by the UART escape inserter and remover.
package uart_pkg;
    localparam logic [7:0] ESC_DEFAULT = 8'hB1;
    typedef enum logic {IDLE, ESC_SEEN} rx_esc_state_t;
endpackage

// File: rtl/rx_escape.sv
// rx_escape: splits the UART-RX byte stream into unescaped data bytes and ESC-prefixed commands,
// each held in a one-entry register with valid/read handshake, plus overrun and ESC-timeout strobes.
module rx_escape
    import uart_pkg::*;
#(
    parameter logic [7:0] ESC     = ESC_DEFAULT,
    parameter int         TIMEOUT = 1024
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic [7:0] DATA_REC_I,
    input  logic       RX_DONE_I,
    output logic [7:0] DATA_REC_O,
    output logic       DATA_VALID_O,
    input  logic       READ_I,
    output logic [7:0] COMMAND_O,
    output logic       COMMAND_VALID_O,
    input  logic       COMMAND_READ_I,
    output logic       OVERRUN_O,
    output logic       ESC_TIMEOUT_O
);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    rx_esc_state_t state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    data_q, data_d, cmd_q, cmd_d;
    logic          dv_q, dv_d, cv_q, cv_d, ov_q, ov_d, to_q, to_d;
    logic          is_esc, del_data, del_cmd, expire;

    always_comb begin
        is_esc   = DATA_REC_I == ESC;
        del_data = RX_DONE_I && ((state_q == IDLE) ? !is_esc : is_esc);
        del_cmd  = RX_DONE_I && state_q == ESC_SEEN && !is_esc;
        expire   = TIMEOUT > 0 && state_q == ESC_SEEN && !RX_DONE_I && timer_q == LAST;
        state_d  = RX_DONE_I ? ((state_q == IDLE && is_esc) ? ESC_SEEN : IDLE)
                             : (expire ? IDLE : state_q);
        timer_d  = (RX_DONE_I && state_q == IDLE && is_esc) ? '0
                 : (!RX_DONE_I && state_q == ESC_SEEN && timer_q != '1) ? timer_q + 1'b1 : timer_q;
        to_d     = expire;
        // A read frees the register in the same cycle a new byte may land in it.
        dv_d     = dv_q && !READ_I;
        cv_d     = cv_q && !COMMAND_READ_I;
        data_d   = data_q;
        cmd_d    = cmd_q;
        ov_d     = (del_data && dv_d) || (del_cmd && cv_d);
        if (del_data && !dv_d) begin
            dv_d   = 1'b1;
            data_d = is_esc ? ESC : DATA_REC_I;
        end
        if (del_cmd && !cv_d) begin
            cv_d  = 1'b1;
            cmd_d = DATA_REC_I;
        end
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q <= IDLE;
            timer_q <= '0;
            data_q  <= 8'h00;
            cmd_q   <= 8'h00;
            dv_q    <= 1'b0;
            cv_q    <= 1'b0;
            ov_q    <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            data_q  <= data_d;
            cmd_q   <= cmd_d;
            dv_q    <= dv_d;
            cv_q    <= cv_d;
            ov_q    <= ov_d;
            to_q    <= to_d;
        end
    end

    assign DATA_REC_O      = data_q;
    assign DATA_VALID_O    = dv_q;
    assign COMMAND_O       = cmd_q;
    assign COMMAND_VALID_O = cv_q;
    assign OVERRUN_O       = ov_q;
    assign ESC_TIMEOUT_O   = to_q;
endmodule

// File: tb/tb_rx_escape.sv
// tb_rx_escape: directed test-plan steps followed by random traffic, every cycle checked
// against a transaction-level model of the escape decoder and its holding registers.
module tb_rx_escape;
    localparam int         TO  = 8;
    localparam logic [7:0] ESC = 8'hB1;

    logic       clk = 1'b0, rst = 1'b1;
    logic [7:0] din = 8'h00;
    logic       rx = 1'b0, rd = 1'b0, crd = 1'b0;
    logic [7:0] dout, cmd;
    logic       dv, cv, ov, tout;

    rx_escape #(.ESC(ESC), .TIMEOUT(TO)) dut (
        .CLK_I(clk), .RST_I(rst), .DATA_REC_I(din), .RX_DONE_I(rx),
        .DATA_REC_O(dout), .DATA_VALID_O(dv), .READ_I(rd),
        .COMMAND_O(cmd), .COMMAND_VALID_O(cv), .COMMAND_READ_I(crd),
        .OVERRUN_O(ov), .ESC_TIMEOUT_O(tout)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    bit       m_pend, m_dv, m_cv, m_ov, m_to;
    int       m_age;
    bit [7:0] m_d, m_c;

    task automatic m_reset();
        m_pend = 0; m_age = 0; m_dv = 0; m_cv = 0; m_ov = 0; m_to = 0; m_d = 0; m_c = 0;
    endtask

    task automatic m_step(input bit r, input bit [7:0] b, input bit rdi, input bit crdi);
        bit dd, dc;
        bit [7:0] val;
        dd = 0; dc = 0; val = b; m_to = 0; m_ov = 0;
        if (r) begin
            if (m_pend) begin
                m_pend = 0;
                if (b == ESC) dd = 1; else dc = 1;
            end else if (b == ESC) begin
                m_pend = 1; m_age = 0;
            end else dd = 1;
        end else if (m_pend) begin
            m_age++;
            if (m_age == TO) begin m_pend = 0; m_to = 1; end
        end
        if (m_dv && rdi) m_dv = 0;
        if (m_cv && crdi) m_cv = 0;
        if (dd) begin if (m_dv) m_ov = 1; else begin m_dv = 1; m_d = val; end end
        if (dc) begin if (m_cv) m_ov = 1; else begin m_cv = 1; m_c = val; end end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("data_valid", {7'b0, dv}, {7'b0, m_dv});
        chk("data", dout, m_d);
        chk("cmd_valid", {7'b0, cv}, {7'b0, m_cv});
        chk("cmd", cmd, m_c);
        chk("overrun", {7'b0, ov}, {7'b0, m_ov});
        chk("timeout", {7'b0, tout}, {7'b0, m_to});
    endtask

    task automatic cyc(input bit r, input bit [7:0] b, input bit rdi, input bit crdi);
        rx = r; din = b; rd = rdi; crd = crdi;
        @(posedge clk);
        m_step(r, b, rdi, crdi);
        #1 check_all();
    endtask

    initial begin
        m_reset();
        repeat (2) @(posedge clk);
        #1 check_all();
        rst = 1'b0;

        cyc(1, 8'h41, 1, 0);
        chk("d41", dout, 8'h41);
        cyc(1, 8'h42, 1, 0);
        chk("d42", dout, 8'h42);
        cyc(0, 8'h00, 1, 0);

        cyc(1, ESC, 0, 0);
        cyc(1, ESC, 0, 0);
        chk("dB1", dout, 8'hB1);
        cyc(0, 8'h00, 1, 0);
        cyc(1, ESC, 0, 0);
        cyc(1, 8'h05, 0, 0);
        chk("c05", cmd, 8'h05);
        repeat (3) cyc(0, 8'h00, 0, 0);
        chk("c05_held", {7'b0, cv}, 8'h01);
        cyc(0, 8'h00, 0, 1);
        chk("c05_read", {7'b0, cv}, 8'h00);

        cyc(1, ESC, 0, 0);
        repeat (8) cyc(0, 8'h00, 0, 0);
        chk("to_pulse", {7'b0, tout}, 8'h01);
        cyc(0, 8'h00, 0, 0);
        cyc(1, 8'h10, 0, 0);
        chk("d10_data", dout, 8'h10);
        cyc(0, 8'h00, 1, 0);

        cyc(1, ESC, 0, 0);
        repeat (7) cyc(0, 8'h00, 0, 0);
        cyc(1, 8'h22, 0, 0);
        chk("late_cmd", cmd, 8'h22);
        cyc(0, 8'h00, 0, 1);

        cyc(1, 8'h01, 0, 0);
        cyc(1, 8'h02, 0, 0);
        chk("ovr_keep", dout, 8'h01);
        chk("ovr_pulse", {7'b0, ov}, 8'h01);
        cyc(1, ESC, 0, 0);
        cyc(1, 8'h07, 0, 0);
        chk("c07", cmd, 8'h07);
        cyc(0, 8'h00, 1, 1);

        cyc(1, ESC, 0, 0);
        #2 rst = 1'b1;
        m_reset();
        #1 check_all();
        #1 rst = 1'b0;
        cyc(1, 8'h33, 0, 0);
        chk("d33", dout, 8'h33);
        repeat (10) cyc(0, 8'h00, 0, 0);

        cyc(1, 8'h55, 1, 0);
        chk("d55", dout, 8'h55);
        chk("d55_ov", {7'b0, ov}, 8'h00);
        cyc(0, 8'h00, 1, 0);

        for (int i = 0; i < 3000; i++) begin
            bit r;
            bit [7:0] b;
            r = $urandom_range(0, 9) < ((i % 300 < 150) ? 7 : 1);
            b = ($urandom_range(0, 2) == 0) ? ESC : 8'($urandom);
            cyc(r, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rx_escape.md
Name: rx_escape

Overview:
- Receive-side counterpart of the TX escape inserter.
- Sits between the UART-RX byte output and the TAP, and splits the raw byte stream into two streams: data bytes and command bytes.
- ESC followed by ESC is delivered as one literal ESC data byte.
- ESC followed by any other byte is delivered as a command.
- Each stream has a one-entry holding register with a valid/read handshake toward the TAP, plus overrun and escape-timeout error strobes.

Parameters:
- ESC, 8'hB1: escape byte value; must match the transmitter.
- TIMEOUT, 1024: clock cycles allowed between an ESC and its follow-up byte. 0 disables the timeout.

Ports:
- CLK_I  in  1  system clock, rising edge.
- RST_I  in  1  reset, asynchronous, active-high.
- DATA_REC_I  in  8  byte from UART-RX.
- RX_DONE_I  in  1  one-cycle strobe: DATA_REC_I is valid this cycle.
- DATA_REC_O  out  8  unescaped data byte to TAP.
- DATA_VALID_O  out  1  DATA_REC_O holds an unread byte.
- READ_I  in  1  TAP consumes the data byte; ignored when DATA_VALID_O=0.
- COMMAND_O  out  8  command byte (byte that followed a single ESC).
- COMMAND_VALID_O  out  1  COMMAND_O holds an unread command.
- COMMAND_READ_I  in  1  TAP consumes the command; ignored when COMMAND_VALID_O=0.
- OVERRUN_O  out  1  one-cycle pulse: a completed byte was dropped because its holding register was full.
- ESC_TIMEOUT_O  out  1  one-cycle pulse: a pending ESC expired and was discarded.

Behaviour:
- Reset:
  - Asynchronous; all outputs 0, DATA_REC_O and COMMAND_O = 8'h00, state IDLE, timer 0.
  - Reset mid-sequence discards any pending ESC and any buffered bytes, with no error pulse.
- All outputs are registered.
- State IDLE, on RX_DONE_I:
  - Byte != ESC: deliver as data.
  - Byte == ESC: go to ESC_SEEN and clear the timer.
- State ESC_SEEN, on RX_DONE_I:
  - Byte == ESC: deliver 8'hB1 as data, go to IDLE.
  - Any other byte (including 8'h00): deliver as a command, go to IDLE.
- State ESC_SEEN, no RX_DONE_I:
  - Timer increments each cycle.
  - With TIMEOUT>0, when the timer equals TIMEOUT-1 and no byte arrives that cycle: go to IDLE, ESC_TIMEOUT_O=1 for the next cycle, nothing delivered.
  - A byte arriving in that same cycle wins; no timeout is raised.
- Delivery latency: DATA_VALID_O or COMMAND_VALID_O rises on the clock edge that samples RX_DONE_I of the completing byte, i.e. visible the following cycle.
- A leading ESC produces no output.
- Holding registers (data and command handled independently):
  - VALID stays high and the byte stays stable until the corresponding read input is sampled high; VALID is low the next cycle.
  - Read and new delivery in the same cycle: the new byte is loaded and VALID stays 1, with no overrun.
  - VALID=1, no read, new delivery: the new byte is dropped, the old byte is kept, OVERRUN_O pulses for one cycle. The decoder state still advances, so the escape state stays in sync with the line.
  - A full data register does not block command delivery, and vice versa.
- Timer width is $clog2(TIMEOUT+1) bits and saturates; no wrap.
- RX_DONE_I is accepted every cycle; back-to-back strobes are legal.

Decomposition:
- Shared package uart_pkg:
  - ESC_DEFAULT = 8'hB1, used by both escape blocks.
  - typedef enum logic {IDLE, ESC_SEEN} rx_esc_state_t.
- No sub-module: the two holding registers are simple enough to live inline.
- The timeout counter may be a generic sat_counter if one already exists in the library; otherwise keep it inline.

Test Plan:
- Bytes 8'h41, 8'h42, one cycle apart, READ_I held 1 -> DATA_REC_O 8'h41 then 8'h42, each valid one cycle after its strobe; COMMAND_VALID_O stays 0.
- Bytes B1, B1 -> one data byte 8'hB1; COMMAND_VALID_O stays 0. Bytes B1, 05 -> COMMAND_O=8'h05, COMMAND_VALID_O held until COMMAND_READ_I; DATA_VALID_O stays 0.
- TIMEOUT=8: byte B1, then idle for 8 cycles -> ESC_TIMEOUT_O pulses once. Following byte 8'h10 -> delivered as data, not a command.
- READ_I=0: bytes 8'h01, 8'h02 -> DATA_REC_O stays 8'h01, OVERRUN_O pulses once. Then B1, 07 -> command delivered normally.
- RST_I asserted asynchronously after B1, then released; byte 8'h33 -> delivered as data; no timeout or overrun pulse.
- DATA_VALID_O=1 with READ_I=1 in the same cycle as the strobe of 8'h55 -> DATA_REC_O=8'h55 next cycle, valid stays 1, no overrun.
